seven_seg_scanner: RTL and testbench

Parametrised multiplexed seven-segment driver: scans `NUM_DIGITS` hex digits onto a shared segment bus with per-digit enable, decimal points, leading-zero blanking, an anti-ghosting guard interval and frame-synchronous input capture. It sits between any 4·N-bit status/result word, such as the N-Queens solution count, and the board's anode and cathode pins.

---
 rtl/sevseg_pkg.sv | 27 ++
 rtl/hex_to_seg.sv | 32 +++
 rtl/seven_seg_scanner.sv | 145 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared types and glyph constants for the seven-segment scanner.
// Glyphs are active-high {g,f,e,d,c,b,a}.
package sevseg_pkg;

  typedef logic [6:0] seg_t;

  localparam int MAX_DIGITS = 16;

  localparam seg_t SEG_0   = 7'h3F;
  localparam seg_t SEG_1   = 7'h06;
  localparam seg_t SEG_2   = 7'h5B;
  localparam seg_t SEG_3   = 7'h4F;
  localparam seg_t SEG_4   = 7'h66;
  localparam seg_t SEG_5   = 7'h6D;
  localparam seg_t SEG_6   = 7'h7D;
  localparam seg_t SEG_7   = 7'h07;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h6F;
  localparam seg_t SEG_A   = 7'h77;
  localparam seg_t SEG_B   = 7'h7C;
  localparam seg_t SEG_C   = 7'h39;
  localparam seg_t SEG_D   = 7'h5E;
  localparam seg_t SEG_E   = 7'h79;
  localparam seg_t SEG_F   = 7'h71;
  localparam seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high segment pattern.
// Covers the full 0-F glyph set.
module hex_to_seg
  import sevseg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       glyph
);

  always_comb begin
    glyph = SEG_OFF;
    unique case (nib)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      4'hF: glyph = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with frame-synchronous capture.
// Optional duty dimming via the SEVSEG_DIM_EN macro (adds brightness port).
module seven_seg_scanner
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_BITS   = 17,
  parameter int GUARD      = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
`ifdef SEVSEG_DIM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NUM_DIGITS - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [DIV_BITS-1:0]     pre;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] val_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   en_sh;
  logic                    blank_sh;
  logic                    fs_pend;
  logic                    tick;
  logic                    wrap;
`ifdef SEVSEG_DIM_EN
  logic [3:0]              br_sh;
`endif

  assign tick = &pre;
  assign wrap = tick && (idx == LAST);

  // Inputs are only sampled on the frame wrap so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre      <= '0;
      idx      <= LAST;
      val_sh   <= '0;
      dp_sh    <= '0;
      en_sh    <= '0;
      blank_sh <= 1'b0;
      fs_pend  <= 1'b0;
`ifdef SEVSEG_DIM_EN
      br_sh    <= '0;
`endif
    end else begin
      pre     <= pre + 1'b1;
      fs_pend <= wrap;
      if (tick) begin
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
      end
      if (wrap) begin
        val_sh   <= value;
        dp_sh    <= dp_in;
        en_sh    <= digit_en;
        blank_sh <= blank_lz;
`ifdef SEVSEG_DIM_EN
        br_sh    <= brightness;
`endif
      end
    end
  end

  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_hi;

  // Walk down from the top digit tracking "everything above is zero".
  always_comb begin
    lz      = '0;
    zero_hi = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_hi = zero_hi && (val_sh[4*i +: 4] == 4'h0);
      lz[i]   = blank_sh && (i != 0) && zero_hi && !dp_sh[i];
    end
  end

  logic [3:0] nib;
  seg_t       glyph;
  logic       show;
  logic       past_guard;
  logic       duty_ok;

  assign nib  = val_sh[4*int'(idx) +: 4];
  assign show = en_sh[idx] && !lz[idx];

  hex_to_seg u_hex (
    .nib   (nib),
    .glyph (glyph)
  );

  generate
    if (GUARD > 0) begin : g_guard
      assign past_guard = (pre >= DIV_BITS'(GUARD));
    end else begin : g_noguard
      assign past_guard = 1'b1;
    end
  endgenerate

`ifdef SEVSEG_DIM_EN
  assign duty_ok = (pre[DIV_BITS-1 -: 4] <= br_sh);
`else
  assign duty_ok = 1'b1;
`endif

  logic [NUM_DIGITS-1:0] an_next;
  seg_t                  seg_next;
  logic                  dp_next;

  always_comb begin
    an_next      = '0;
    an_next[idx] = show && past_guard && duty_ok;
    seg_next     = show ? glyph : SEG_OFF;
    dp_next      = show && dp_sh[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anodes      <= {NUM_DIGITS{INV}};
      seg         <= {7{INV}};
      dp          <= INV;
      frame_start <= 1'b0;
    end else begin
      anodes      <= an_next ^ {NUM_DIGITS{INV}};
      seg         <= seg_next ^ {7{INV}};
      dp          <= dp_next ^ INV;
      frame_start <= fs_pend;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (4 digits, active-low).
// Dimming scenario is compiled in when SEVSEG_DIM_EN is defined.
module tb_seven_seg_scanner;

  localparam int N = 4;
`ifdef SEVSEG_DIM_EN
  localparam int D = 8;
  localparam int G = 0;
`else
  localparam int D = 4;
  localparam int G = 2;
`endif
  localparam int SLOT  = 1 << D;
  localparam int FRAME = N * SLOT;
  localparam int W     = N + 9;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4*N-1:0] value = '0;
  logic [N-1:0]   dp_in = '0;
  logic [N-1:0]   digit_en = '0;
  logic           blank_lz = 1'b0;
`ifdef SEVSEG_DIM_EN
  logic [3:0]     brightness = 4'hF;
`endif
  logic [N-1:0]   anodes;
  logic [6:0]     seg;
  logic           dp;
  logic           frame_start;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS (N),
    .DIV_BITS   (D),
    .GUARD      (G),
    .ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .blank_lz    (blank_lz),
`ifdef SEVSEG_DIM_EN
    .brightness  (brightness),
`endif
    .anodes      (anodes),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // Standard active-high glyphs {g,f,e,d,c,b,a}
  logic [6:0] glyphs [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: frame contents captured at each frame boundary,
  // slot and offset derived arithmetically from clocks since reset.
  int             m_cyc;
  logic [4*N-1:0] m_val;
  logic [N-1:0]   m_dp;
  logic [N-1:0]   m_en;
  logic           m_blank;
  logic [3:0]     m_br;
  logic           m_pend;
  logic [N-1:0]   exp_an;
  logic [6:0]     exp_seg;
  logic           exp_dp;
  logic           exp_fs;

  function automatic int slot_of(input int c);
    return (N - 1 + c / SLOT) % N;
  endfunction

  function automatic bit dark(input int i);
    if (!m_en[i]) return 1'b1;
    return m_blank && i > 0 && (m_val >> (4*i)) == '0 && !m_dp[i];
  endfunction

  function automatic logic [N-1:0] model_an(input int c);
    int i = slot_of(c);
    int p = c % SLOT;
    logic [N-1:0] r = '0;
    bit on = !dark(i) && p >= G;
    if ((p >> (D - 4)) > int'(m_br)) on = 1'b0;
    if (on) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [6:0] model_seg(input int c);
    int i = slot_of(c);
    if (dark(i)) return 7'h00;
    return glyphs[(m_val >> (4*i)) & 'hF];
  endfunction

  function automatic logic model_dp(input int c);
    int i = slot_of(c);
    return !dark(i) && m_dp[i];
  endfunction

  function automatic bit is_wrap(input int c);
    return (c % SLOT == SLOT - 1) && slot_of(c) == N - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc   <= 0;
      m_val   <= '0;
      m_dp    <= '0;
      m_en    <= '0;
      m_blank <= 1'b0;
      m_br    <= 4'h0;
      m_pend  <= 1'b0;
      exp_an  <= '1;
      exp_seg <= 7'h7F;
      exp_dp  <= 1'b1;
      exp_fs  <= 1'b0;
    end else begin
      exp_an  <= ~model_an(m_cyc);
      exp_seg <= ~model_seg(m_cyc);
      exp_dp  <= ~model_dp(m_cyc);
      exp_fs  <= m_pend;
      m_pend  <= is_wrap(m_cyc);
      m_cyc   <= m_cyc + 1;
      if (is_wrap(m_cyc)) begin
        m_val   <= value;
        m_dp    <= dp_in;
        m_en    <= digit_en;
        m_blank <= blank_lz;
`ifdef SEVSEG_DIM_EN
        m_br    <= brightness;
`else
        m_br    <= 4'hF;
`endif
      end
    end
  end

  task automatic test_reset();
    value = 16'h12AF;
    digit_en = '1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({anodes, seg, dp} !== {{N{1'b1}}, 7'h7F, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_outputs got=%h want=%h",
               {anodes, seg, dp}, {{N{1'b1}}, 7'h7F, 1'b1});
    end
    compared++;
    if (frame_start !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_fs got=%b want=0", frame_start);
    end
  endtask

  // Release reset, expect the first frame_start SLOT+1 clocks later.
  task automatic test_first_frame(input string name);
    int first = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3 * SLOT; k++) begin
      @(posedge clk);
      #1;
      if (frame_start === 1'b1 && first == 0) first = k;
      compared++;
      if ({anodes, seg, dp, frame_start} !==
          {exp_an, exp_seg, exp_dp, exp_fs}) begin
        mismatched++;
        $display("FAIL %s_cycle k=%0d got=%h want=%h", name, k,
                 {anodes, seg, dp, frame_start},
                 {exp_an, exp_seg, exp_dp, exp_fs});
      end
    end
    compared++;
    if (first != SLOT + 1) begin
      mismatched++;
      $display("FAIL %s_latency got=%0d want=%0d", name, first, SLOT + 1);
    end
  endtask

  task automatic test_scan();
    int cnt [N] = '{default: 0};
    int fs_at [$];
    logic [15:0] ref_val = 16'h12AF;
    value = ref_val;
    dp_in = '0;
    digit_en = '1;
    blank_lz = 1'b0;
    for (int k = 0; k < 4 * FRAME; k++) begin
      @(posedge clk);
      #1;
      compared++;
      if ({anodes, seg, dp, frame_start} !==
          {exp_an, exp_seg, exp_dp, exp_fs}) begin
        mismatched++;
        $display("FAIL scan_cycle k=%0d got=%h want=%h", k,
                 {anodes, seg, dp, frame_start},
                 {exp_an, exp_seg, exp_dp, exp_fs});
      end
      if (frame_start === 1'b1) fs_at.push_back(k);
      if (k >= 2 * FRAME) begin
        for (int i = 0; i < N; i++) begin
          if (anodes[i] === 1'b0) begin
            cnt[i]++;
            compared++;
            if (seg !== ~glyphs[ref_val[4*i +: 4]]) begin
              mismatched++;
              $display("FAIL scan_glyph d=%0d got=%h want=%h", i, seg,
                       ~glyphs[ref_val[4*i +: 4]]);
            end
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      compared++;
      if (cnt[i] != 2 * (SLOT - G)) begin
        mismatched++;
        $display("FAIL scan_ontime d=%0d got=%0d want=%0d", i, cnt[i],
                 2 * (SLOT - G));
      end
    end
    compared++;
    if (fs_at.size() < 3 || fs_at[2] - fs_at[1] != FRAME) begin
      mismatched++;
      $display("FAIL scan_fs_period got=%0d pulses want period %0d",
               fs_at.size(), FRAME);
    end
  endtask

  // Settle one frame, then count anode on-time per digit over two frames.
  task automatic run_counted(input string name, output int cnt [N],
                             output int dp_bad);
    cnt = '{default: 0};
    dp_bad = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(posedge clk);
      #1;
      compared++;
      if ({anodes, seg, dp, frame_start} !==
          {exp_an, exp_seg, exp_dp, exp_fs}) begin
        mismatched++;
        $display("FAIL %s_cycle k=%0d got=%h want=%h", name, k,
                 {anodes, seg, dp, frame_start},
                 {exp_an, exp_seg, exp_dp, exp_fs});
      end
      if (k >= FRAME) begin
        for (int i = 0; i < N; i++) begin
          if (anodes[i] === 1'b0) cnt[i]++;
        end
        if (anodes[3] === 1'b0 && dp !== 1'b0) dp_bad++;
      end
    end
  endtask

  task automatic test_blanking();
    int cnt [N];
    int dp_bad;
    int want [N];
    value = 16'h0030;
    blank_lz = 1'b1;
    dp_in = '0;
    digit_en = '1;
    run_counted("blank", cnt, dp_bad);
    want = '{2 * (SLOT - G), 2 * (SLOT - G), 0, 0};
    for (int i = 0; i < N; i++) begin
      compared++;
      if (cnt[i] != want[i]) begin
        mismatched++;
        $display("FAIL blank_ontime d=%0d got=%0d want=%0d", i, cnt[i],
                 want[i]);
      end
    end
    dp_in = 4'b1000;
    run_counted("blank_dp", cnt, dp_bad);
    want = '{2 * (SLOT - G), 2 * (SLOT - G), 0, 2 * (SLOT - G)};
    for (int i = 0; i < N; i++) begin
      compared++;
      if (cnt[i] != want[i]) begin
        mismatched++;
        $display("FAIL blank_dp_ontime d=%0d got=%0d want=%0d", i, cnt[i],
                 want[i]);
      end
    end
    compared++;
    if (dp_bad != 0) begin
      mismatched++;
      $display("FAIL blank_dp_lit got=%0d bad cycles want=0", dp_bad);
    end
    blank_lz = 1'b0;
    dp_in = '0;
  endtask

  task automatic test_digit_en();
    int cnt [N];
    int dp_bad;
    int want [N];
    value = 16'h8421;
    digit_en = 4'b0101;
    run_counted("den", cnt, dp_bad);
    want = '{2 * (SLOT - G), 0, 2 * (SLOT - G), 0};
    for (int i = 0; i < N; i++) begin
      compared++;
      if (cnt[i] != want[i]) begin
        mismatched++;
        $display("FAIL den_ontime d=%0d got=%0d want=%0d", i, cnt[i],
                 want[i]);
      end
    end
    digit_en = '1;
  endtask

  task automatic test_torn();
    int old_bad = 0;
    int new_bad = 0;
    int seen = 0;
    int left = 0;
    value = 16'h1111;
    for (int k = 0; k < 2 * FRAME + 2 && seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (k > FRAME && frame_start === 1'b1) seen = 1;
    end
    compared++;
    if (seen == 0) begin
      mismatched++;
      $display("FAIL torn_sync got=no frame_start want=pulse");
    end
    repeat (FRAME / 2) @(posedge clk);
    #1;
    value = 16'h2222;
    seen = 0;
    for (int k = 0; k < 2 * FRAME && (seen == 0 || left > 0); k++) begin
      @(posedge clk);
      #1;
      if (frame_start === 1'b1 && seen == 0) begin
        seen = 1;
        left = FRAME;
      end
      if (anodes !== '1) begin
        if (seen == 0 && seg !== ~glyphs[1]) old_bad++;
        if (seen != 0 && seg !== ~glyphs[2]) new_bad++;
      end
      if (left > 0) left--;
      compared++;
      if ({anodes, seg, dp, frame_start} !==
          {exp_an, exp_seg, exp_dp, exp_fs}) begin
        mismatched++;
        $display("FAIL torn_cycle k=%0d got=%h want=%h", k,
                 {anodes, seg, dp, frame_start},
                 {exp_an, exp_seg, exp_dp, exp_fs});
      end
    end
    compared++;
    if (old_bad != 0 || new_bad != 0 || seen == 0) begin
      mismatched++;
      $display("FAIL torn_frames got old_bad=%0d new_bad=%0d seen=%0d want 0 0 1",
               old_bad, new_bad, seen);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      int hold = $urandom_range(FRAME / 3, 2 * FRAME);
      value = 16'($urandom);
      if ($urandom_range(0, 1) == 1) value[15:8] = '0;
      dp_in = 4'($urandom);
      digit_en = 4'($urandom);
      blank_lz = 1'($urandom);
`ifdef SEVSEG_DIM_EN
      brightness = 4'($urandom);
`endif
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        compared++;
        if ({anodes, seg, dp, frame_start} !==
            {exp_an, exp_seg, exp_dp, exp_fs}) begin
          mismatched++;
          $display("FAIL rand_cycle t=%0d k=%0d got=%h want=%h", t, k,
                   {anodes, seg, dp, frame_start},
                   {exp_an, exp_seg, exp_dp, exp_fs});
        end
      end
    end
    dp_in = '0;
    digit_en = '1;
    blank_lz = 1'b0;
`ifdef SEVSEG_DIM_EN
    brightness = 4'hF;
`endif
  endtask

  task automatic test_reset_mid();
    value = 16'hFFFF;
    repeat (SLOT + SLOT / 2 + 5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({anodes, seg, dp, frame_start} !==
        {{N{1'b1}}, 7'h7F, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL rstmid_async got=%h want=%h",
               {anodes, seg, dp, frame_start},
               {{N{1'b1}}, 7'h7F, 1'b1, 1'b0});
    end
    repeat (2) @(posedge clk);
    test_first_frame("rstmid");
  endtask

`ifdef SEVSEG_DIM_EN
  task automatic test_dim();
    int cnt [N];
    int dp_bad;
    int want [2] = '{64, 256};
    logic [3:0] lvl [2] = '{4'd3, 4'd15};
    value = 16'h8888;
    digit_en = '1;
    for (int j = 0; j < 2; j++) begin
      brightness = lvl[j];
      run_counted("dim", cnt, dp_bad);
      compared++;
      if (cnt[0] != 2 * want[j]) begin
        mismatched++;
        $display("FAIL dim_ontime br=%0d got=%0d want=%0d", lvl[j],
                 cnt[0], 2 * want[j]);
      end
    end
    brightness = 4'hF;
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame("first");
    test_scan();
    test_blanking();
    test_digit_en();
    test_torn();
    test_random();
`ifdef SEVSEG_DIM_EN
    test_dim();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
